// File: rtl/pkg_rv32_types.sv
// Shared RV32 types for the branch resolve slice: control-flow kinds,
// branch funct3 encodings and the default direction-counter type.
package pkg_rv32_types;

    localparam int RV_XLEN      = 32;
    localparam int BHT_CTR_BITS = 2;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2,
        BR_NONE = 2'd3
    } br_kind_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [BHT_CTR_BITS-1:0] bht_ctr_t;

endpackage

// File: rtl/rv32_branch_resolve_unit_if.sv
// EX/fetch-side bundle of the branch resolve unit: lookup, EX operands,
// registered resolution and perf counters.
interface rv32_branch_resolve_unit_if
    import pkg_rv32_types::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int PERF_W = 32
);
    logic              lk_valid;
    logic [XLEN-1:0]   lk_pc;
    logic              lk_taken;

    logic              ex_valid;
    br_kind_t          ex_kind;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1;
    logic [XLEN-1:0]   ex_rs2;
    logic [XLEN-1:0]   ex_imm;
    logic              ex_pred_taken;
    logic              flush;

    logic              res_valid;
    logic              res_taken;
    logic [XLEN-1:0]   res_target;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              misalign;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispred;

    modport master (
        output lk_valid, lk_pc, ex_valid, ex_kind, ex_funct3, ex_pc,
               ex_rs1, ex_rs2, ex_imm, ex_pred_taken, flush,
        input  lk_taken, res_valid, res_taken, res_target, redirect,
               redirect_pc, misalign, perf_branches, perf_mispred
    );

    modport slave (
        input  lk_valid, lk_pc, ex_valid, ex_kind, ex_funct3, ex_pc,
               ex_rs1, ex_rs2, ex_imm, ex_pred_taken, flush,
        output lk_taken, res_valid, res_taken, res_target, redirect,
               redirect_pc, misalign, perf_branches, perf_mispred
    );

endinterface

// File: rtl/rv32_bht.sv
// Branch history table: saturating direction counters with a registered
// read port and a resolve-time update port (read sees pre-update value).
module rv32_bht #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] wr_cur;

    assign wr_cur = ctr_q[wr_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
            rd_taken <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_taken <= ctr_q[rd_idx][CTR_BITS-1];
            end
            if (wr_en) begin
                if (wr_taken && wr_cur != CTR_MAX) begin
                    ctr_q[wr_idx] <= wr_cur + CTR_ONE;
                end else if (!wr_taken && wr_cur != '0) begin
                    ctr_q[wr_idx] <= wr_cur - CTR_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/rv32_branch_resolve_unit.sv
// Resolves conditional branches and jumps in EX, registers the outcome one
// cycle later with redirect/misalign flags, trains the BHT and counts events.
module rv32_branch_resolve_unit
    import pkg_rv32_types::*;
#(
    parameter int XLEN        = RV_XLEN,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = BHT_CTR_BITS,
    parameter int PERF_W      = 32
) (
    input logic                       clk,
    input logic                       rst,
    rv32_branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

    logic            cond_taken;
    logic            ex_taken;
    logic            ex_redirect;
    logic            capture;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] rs1_imm;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ex_target;

    logic             res_valid_q;
    logic             taken_q;
    logic             redir_q;
    logic             cond_q;
    logic [XLEN-1:0]  target_q;
    logic [XLEN-1:0]  rpc_q;
    logic [IDX_W-1:0] idx_q;
    logic             misalign_w;
    logic             redirect_w;

    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_mp_q;
    logic              unused_lk_pc;

    assign pc_imm   = bus.ex_pc + bus.ex_imm;
    assign rs1_imm  = bus.ex_rs1 + bus.ex_imm;
    assign pc_plus4 = bus.ex_pc + XLEN'(4);

    always_comb begin
        cond_taken = 1'b0;
        case (bus.ex_funct3)
            F3_BEQ:  cond_taken = (bus.ex_rs1 == bus.ex_rs2);
            F3_BNE:  cond_taken = (bus.ex_rs1 != bus.ex_rs2);
            F3_BLT:  cond_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            F3_BGE:  cond_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            F3_BLTU: cond_taken = (bus.ex_rs1 <  bus.ex_rs2);
            F3_BGEU: cond_taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: cond_taken = 1'b0;
        endcase
    end

    // JALR always redirects: fetch cannot know a register-indirect target.
    always_comb begin
        ex_taken    = 1'b0;
        ex_target   = pc_imm;
        ex_redirect = 1'b0;
        case (bus.ex_kind)
            BR_COND: begin
                ex_taken    = cond_taken;
                ex_redirect = (cond_taken != bus.ex_pred_taken);
            end
            BR_JAL: begin
                ex_taken    = 1'b1;
                ex_redirect = !bus.ex_pred_taken;
            end
            BR_JALR: begin
                ex_taken    = 1'b1;
                ex_target   = rs1_imm & LSB_CLR;
                ex_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    assign capture = bus.ex_valid && !bus.flush && (bus.ex_kind != BR_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            redir_q     <= 1'b0;
            cond_q      <= 1'b0;
            target_q    <= '0;
            rpc_q       <= '0;
            idx_q       <= '0;
        end else begin
            res_valid_q <= capture;
            if (capture) begin
                taken_q  <= ex_taken;
                redir_q  <= ex_redirect;
                cond_q   <= (bus.ex_kind == BR_COND);
                target_q <= ex_target;
                rpc_q    <= ex_taken ? ex_target : pc_plus4;
                idx_q    <= bus.ex_pc[IDX_W+1:2];
            end
        end
    end

    // A misaligned taken target traps instead of steering fetch.
    assign misalign_w = res_valid_q && taken_q && target_q[1];
    assign redirect_w = res_valid_q && redir_q && !misalign_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (res_valid_q && !(&perf_br_q)) begin
                perf_br_q <= perf_br_q + PERF_W'(1);
            end
            if (redirect_w && !(&perf_mp_q)) begin
                perf_mp_q <= perf_mp_q + PERF_W'(1);
            end
        end
    end

    rv32_bht #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (bus.lk_valid),
        .rd_idx   (bus.lk_pc[IDX_W+1:2]),
        .rd_taken (bus.lk_taken),
        .wr_en    (res_valid_q && cond_q),
        .wr_idx   (idx_q),
        .wr_taken (taken_q)
    );

    assign unused_lk_pc = ^{bus.lk_pc[XLEN-1:IDX_W+2], bus.lk_pc[1:0]};

    assign bus.res_valid     = res_valid_q;
    assign bus.res_taken     = res_valid_q && taken_q;
    assign bus.res_target    = target_q;
    assign bus.redirect      = redirect_w;
    assign bus.redirect_pc   = rpc_q;
    assign bus.misalign      = misalign_w;
    assign bus.perf_branches = perf_br_q;
    assign bus.perf_mispred  = perf_mp_q;

endmodule
